// File: rtl/spi_peripheral_if.sv
// SPI peripheral bus: serial pins plus parallel word side.
// master drives the pins and tx word, slave is the peripheral.
interface spi_peripheral_if #(
  parameter int TX_WIDTH = 24,
  parameter int RX_WIDTH = 24
);
  logic                sck;
  logic                cs;
  logic                sdi;
  logic                sdo;
  logic [TX_WIDTH-1:0] tx_data;
  logic [RX_WIDTH-1:0] rx_data;
  logic                rx_valid;
  logic                frame_err;
  logic                busy;

  modport master (
    output sck, cs, sdi, tx_data,
    input  sdo, rx_data, rx_valid, frame_err, busy
  );

  modport slave (
    input  sck, cs, sdi, tx_data,
    output sdo, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral, oversampled by clk.
// Full-duplex frame: tx word out on sdo, rx word in from sdi.
module spi_peripheral #(
  parameter int TX_WIDTH  = 24,
  parameter int RX_WIDTH  = 24,
  parameter int CNT_WIDTH = 6
) (
  input logic             clk,
  input logic             nrst,
  spi_peripheral_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACTIVE,
    FINISH
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RX_CNT =
    CNT_WIDTH'(RX_WIDTH);

  state_t state, state_nx;

  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] sdi_q;

  logic [CNT_WIDTH-1:0] cnt;
  logic [TX_WIDTH-1:0]  tx_sr;
  logic [RX_WIDTH-1:0]  rx_sr;
  logic                 cs_pend;

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;
  logic st_load, st_active, st_finish;

  // [1:0] is the synchronizer, [2] is the edge reference
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_q <= '0;
      cs_q  <= '0;
      sdi_q <= '0;
    end else begin
      sck_q <= {sck_q[1:0], bus.sck};
      cs_q  <= {cs_q[1:0], bus.cs};
      sdi_q <= {sdi_q[0], bus.sdi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (cs_fall || cs_pend) state_nx = LOAD;
      LOAD:   state_nx = ACTIVE;
      ACTIVE: if (cs_rise) state_nx = FINISH;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    st_load   = 1'b0;
    st_active = 1'b0;
    st_finish = 1'b0;
    bus.busy  = 1'b1;
    unique case (state)
      IDLE:   bus.busy  = 1'b0;
      LOAD:   st_load   = 1'b1;
      ACTIVE: st_active = 1'b1;
      FINISH: st_finish = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

  // A cs fall seen in FINISH would be lost on the way to IDLE
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cs_pend <= 1'b0;
    else       cs_pend <= st_finish & cs_fall;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt   <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
    end else if (st_load) begin
      cnt   <= '0;
      tx_sr <= bus.tx_data;
      rx_sr <= '0;
    end else if (st_active) begin
      if (sck_rise) begin
        rx_sr <= {rx_sr[RX_WIDTH-2:0], sdi_q[1]};
        if (!(&cnt)) cnt <= cnt + 1'b1;
      end
      if (sck_fall) tx_sr <= {tx_sr[TX_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.rx_valid  <= st_finish & (cnt >= RX_CNT);
      bus.frame_err <= st_finish & (cnt < RX_CNT);
      if (st_finish && cnt >= RX_CNT) bus.rx_data <= rx_sr;
    end
  end

  assign bus.sdo = tx_sr[TX_WIDTH-1];

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral with a word scoreboard.
// Expected rx words / errors queue up per frame, popped on pulses.
module tb_spi_peripheral;

  logic clk;
  logic nrst;

  spi_peripheral_if #(.TX_WIDTH(24), .RX_WIDTH(24)) bus ();

  spi_peripheral #(
    .TX_WIDTH(24),
    .RX_WIDTH(24),
    .CNT_WIDTH(6)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  typedef struct {
    bit          err;
    logic [23:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit err, input logic [23:0] d);
    exp_t e;
    e.err  = err;
    e.data = d;
    q.push_back(e);
  endtask

  // One frame of n SCK cycles, 10 clk period, sdo sampled on rise
  task automatic frame(input int n,
                       input logic [63:0] bits,
                       output logic [63:0] got,
                       output int lat);
    got    = '0;
    bus.cs = 1'b0;
    tick(5);
    chk("busy_in_frame", 64'(bus.busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      bus.sdi = bits[n-1-i];
      tick(5);
      got     = {got[62:0], bus.sdo};
      bus.sck = 1'b1;
      tick(5);
      bus.sck = 1'b0;
    end
    tick(5);
    bus.cs = 1'b1;
    lat    = 0;
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      if (bus.rx_valid || bus.frame_err) begin
        lat = c;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.rx_valid || bus.frame_err) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pulse got=%b%b exp=none",
               bus.rx_valid, bus.frame_err);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        total++;
        assert ({bus.frame_err, bus.rx_valid, bus.rx_data}
                === {e.err, ~e.err, e.data}) else begin
          bad++;
          $error("FAIL pulse_word got=%b/%b/%h exp=%b/%b/%h",
                 bus.frame_err, bus.rx_valid, bus.rx_data,
                 e.err, ~e.err, e.data);
        end
      end
    end
  end

  logic [63:0] got;
  int          lat;

  initial begin
    nrst        = 1'b0;
    bus.sck     = 1'b0;
    bus.cs      = 1'b1;
    bus.sdi     = 1'b0;
    bus.tx_data = 24'hA5C3F0;
    tick(2);
    chk("reset_outs",
        64'({bus.rx_data, bus.rx_valid, bus.frame_err,
             bus.busy, bus.sdo}), 64'd0);
    nrst = 1'b1;
    tick(4);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // SCK activity with cs high must be ignored
    for (int i = 0; i < 6; i++) begin
      bus.sck = ~bus.sck;
      tick(3);
      chk("sck_cs_high", 64'({bus.busy, bus.sdo}), 64'd0);
    end
    bus.sck = 1'b0;
    tick(4);

    push(1'b0, 24'h123456);
    frame(24, 64'h123456, got, lat);
    chk("sdo_24", got, 64'hA5C3F0);
    chk("lat_24", 64'(lat), 64'd4);
    tick(2);
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("rx_hold", 64'(bus.rx_data), 64'h123456);

    push(1'b0, 24'hBEEF01);
    frame(40, 64'h0000_BEEF01, got, lat);
    chk("sdo_40", got, 64'hA5C3F0_0000);
    chk("lat_40", 64'(lat), 64'd4);
    tick(3);

    push(1'b1, 24'hBEEF01);
    frame(10, 64'h3FF, got, lat);
    chk("sdo_10", got, 64'h297);
    chk("lat_err", 64'(lat), 64'd4);
    tick(2);
    chk("rx_unchanged", 64'(bus.rx_data), 64'hBEEF01);

    // reset in the middle of a frame after 12 SCK edges
    bus.cs = 1'b0;
    tick(5);
    for (int i = 0; i < 6; i++) begin
      bus.sdi = i[0];
      tick(5);
      bus.sck = 1'b1;
      tick(5);
      bus.sck = 1'b0;
    end
    tick(2);
    chk("busy_mid", 64'(bus.busy), 64'd1);
    nrst = 1'b0;
    #1;
    chk("async_reset",
        64'({bus.rx_data, bus.rx_valid, bus.frame_err,
             bus.busy, bus.sdo}), 64'd0);
    tick(3);
    nrst = 1'b1;
    tick(6);
    chk("wait_fresh_cs", 64'(bus.busy), 64'd0);
    bus.cs = 1'b1;
    tick(5);

    push(1'b0, 24'h00FF00);
    frame(24, 64'h00FF00, got, lat);
    chk("sdo_post_rst", got, 64'hA5C3F0);
    chk("lat_post_rst", 64'(lat), 64'd4);
    tick(3);

    // back-to-back frames, tx word changed in the gap
    bus.tx_data = 24'hABCDEF;
    tick(2);
    push(1'b0, 24'h111111);
    frame(24, 64'h111111, got, lat);
    chk("sdo_b2b_1", got, 64'hABCDEF);
    chk("lat_b2b_1", 64'(lat), 64'd4);
    bus.tx_data = 24'h13579B;
    tick(1);
    push(1'b0, 24'h222222);
    frame(24, 64'h222222, got, lat);
    chk("sdo_b2b_2", got, 64'h13579B);
    chk("lat_b2b_2", 64'(lat), 64'd4);
    tick(4);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
